mem_arb_ctrl: RTL

- Parametrised byte-serial memory controller for the RISC-V core.
- Arbitrates NUM_CH requesters (channel 0 = I-cache, channel 1 = MEM stage, extra channels for a future D-cache or prefetcher) onto the single 8-bit RAM port.
- Serialises each variable-length load/store into BUS_W-wide RAM beats and returns assembled read data.
- Improves on the current controller: any channel count, any transfer length up to DATA_W/8, registered arbitration, explicit rdy_in freeze and an optional read-abort.

---
 rtl/mem_arb_ctrl.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/mem_arb_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_arb_ctrl
//  Purpose  : NUM_CH-way priority arbiter and byte-serial load/store engine
//             onto a single BUS_W-wide RAM port. Optional read-abort is
//             enabled by defining MEMCTRL_READ_ABORT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb_ctrl #(
    parameter int NUM_CH = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int BUS_W  = 8,
    parameter int LEN_W  = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic [NUM_CH-1:0]        req_in,
    input  logic [NUM_CH-1:0]        rw_in,
    input  logic [NUM_CH*ADDR_W-1:0] addr_in,
    input  logic [NUM_CH*DATA_W-1:0] wdata_in,
    input  logic [NUM_CH*LEN_W-1:0]  len_in,
    input  logic [BUS_W-1:0]         ram_data_in,
    output logic                     ram_rw_out,
    output logic [ADDR_W-1:0]        ram_addr_out,
    output logic [BUS_W-1:0]         ram_data_out,
    output logic [NUM_CH-1:0]        busy_out,
    output logic [NUM_CH-1:0]        done_out,
    output logic [DATA_W-1:0]        rdata_out
);

    localparam int              NB    = DATA_W / BUS_W;
    localparam int              CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [LEN_W-1:0] C_NB = LEN_W'(NB);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t              state_q;
    logic [CH_W-1:0]     ch_q;
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   asm_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [NUM_CH-1:0]   done_q;

    logic [NUM_CH-1:0]   w_cand;
    logic                w_any;
    logic [CH_W-1:0]     w_win;
    logic                w_rw;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_wdata;
    logic [LEN_W-1:0]    w_len;
    logic [NUM_CH-1:0]   w_act;
    logic [NUM_CH-1:0]   w_win_oh;

    // A channel whose done pulse is visible this cycle still holds req; skip it.
    always_comb begin
        w_cand  = req_in & ~done_q;
        w_any   = |w_cand;
        w_win   = '0;
        w_rw    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_len   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_cand[c]) begin
                w_win   = CH_W'(c);
                w_rw    = rw_in[c];
                w_addr  = addr_in[c*ADDR_W +: ADDR_W];
                w_wdata = wdata_in[c*DATA_W +: DATA_W];
                w_len   = (len_in[c*LEN_W +: LEN_W] > C_NB) ? C_NB : len_in[c*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            done_q  <= '0;
        end else if (rdy_in) begin
            done_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (w_any) begin
                        ch_q    <= w_win;
                        rw_q    <= w_rw;
                        addr_q  <= w_addr;
                        wdata_q <= w_wdata;
                        len_q   <= w_len;
                        cnt_q   <= '0;
                        asm_q   <= '0;
                        if (w_len == '0)
                            state_q <= S_FIN;
                        else
                            state_q <= w_rw ? S_WR : S_RD;
                    end
                end
                S_RD: begin
`ifdef MEMCTRL_READ_ABORT_EN
                    if (!req_in[ch_q])
                        state_q <= S_IDLE;
                    else
`endif
                    begin
                        // Data for the address issued at cnt=k-1 arrives at cnt=k.
                        for (int k = 0; k < NB; k++) begin
                            if (cnt_q == LEN_W'(k + 1))
                                asm_q[k*BUS_W +: BUS_W] <= ram_data_in;
                        end
                        cnt_q <= cnt_q + LEN_W'(1);
                        if (cnt_q == len_q)
                            state_q <= S_FIN;
                    end
                end
                S_WR: begin
                    cnt_q <= cnt_q + LEN_W'(1);
                    if (cnt_q == len_q - LEN_W'(1))
                        state_q <= S_FIN;
                end
                S_FIN: begin
                    done_q[ch_q] <= 1'b1;
                    rdata_q      <= rw_q ? '0 : asm_q;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        ram_rw_out   = 1'b0;
        ram_addr_out = '0;
        ram_data_out = '0;
        if (state_q == S_RD && cnt_q < len_q)
            ram_addr_out = addr_q + ADDR_W'(cnt_q);
        if (state_q == S_WR) begin
            // Gating with rdy_in keeps a frozen beat from being written twice.
            ram_rw_out   = rdy_in;
            ram_addr_out = addr_q + ADDR_W'(cnt_q);
            for (int k = 0; k < NB; k++) begin
                if (cnt_q == LEN_W'(k))
                    ram_data_out = wdata_q[k*BUS_W +: BUS_W];
            end
        end
    end

    always_comb begin
        w_act    = '0;
        w_win_oh = '0;
        if (state_q != S_IDLE)
            w_act[ch_q] = 1'b1;
        if (w_any && rdy_in)
            w_win_oh[w_win] = 1'b1;
        if (rst_in)
            busy_out = '0;
        else if (state_q == S_IDLE)
            busy_out = w_cand & ~w_win_oh;
        else
            busy_out = w_act | w_cand;
    end

    assign done_out  = done_q;
    assign rdata_out = rdata_q;

endmodule
`default_nettype wire
